// File: rtl/pmod_da4_pkg.sv
// rtl/pmod_da4_pkg.sv - shared types, command codes and frame builder for the PMOD DA4 sequencer
//
// Purpose: FSM state encoding, AD5628 command codes, the fixed
// internal-reference setup word and a helper that assembles a 32-bit frame.
// Ports: none (package).

package pmod_da4_pkg;

  typedef enum logic [2:0] {
    ST_RESET_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_TAIL,
    ST_GAP
  } state_e;

  localparam logic [3:0]  CMD_WRITE_UPDATE = 4'h3;
  localparam logic [3:0]  CMD_REF_SETUP    = 4'h8;
  // Reference setup: cmd 8, address/data don't-care, LSB set enables the internal reference.
  localparam logic [31:0] REF_ON_WORD      = {4'h0, CMD_REF_SETUP, 24'h000001};

  // Frame layout: [31:28]=0, [27:24]=cmd, [23:20]=addr, [19:8]=data, [7:0]=0.
  function automatic logic [31:0] build_frame(input logic [3:0]  cmd,
                                              input logic [3:0]  addr,
                                              input logic [11:0] data);
    return {4'h0, cmd, addr, data, 8'h00};
  endfunction

endpackage

// File: rtl/pmod_da4_spi_sequencer_if.sv
// rtl/pmod_da4_spi_sequencer_if.sv - register-bank and PMOD pin bundle for the DA4 sequencer
//
// Purpose: groups the register-file side (channel values, write strobes,
// soft_init) and the DAC side (SYNC_N/SCLK/DIN) plus status flags.
// slave modport : used by the sequencer (drives pins and status).
// master modport: used by the register file / testbench.
//   ch_data   12*NUM_CH  channel values, channel n at [12n+11:12n]
//   ch_wr     NUM_CH     one-cycle write strobes
//   soft_init 1          one-cycle request to resend the reference frame
//   SYNC_N, SCLK, DIN    DAC serial pins
//   busy, init_done, ch_done[NUM_CH], pending[NUM_CH]  status

interface pmod_da4_spi_sequencer_if #(
  parameter int NUM_CH = 8
);
  logic [12*NUM_CH-1:0] ch_data;
  logic [NUM_CH-1:0]    ch_wr;
  logic                 soft_init;
  logic                 SYNC_N;
  logic                 SCLK;
  logic                 DIN;
  logic                 busy;
  logic                 init_done;
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH-1:0]    pending;

  modport slave (
    input  ch_data, ch_wr, soft_init,
    output SYNC_N, SCLK, DIN, busy, init_done, ch_done, pending
  );

  modport master (
    output ch_data, ch_wr, soft_init,
    input  SYNC_N, SCLK, DIN, busy, init_done, ch_done, pending
  );
endinterface

// File: rtl/pmod_da4_rr_arbiter.sv
// rtl/pmod_da4_rr_arbiter.sv - 8-way combinational round-robin grant for pending channels
//
// Purpose: picks the first requesting index at or after ptr_i, wrapping 7->0.
// The pointer itself is owned by the parent.
//   req_i[7:0]        request (pending) vector
//   ptr_i[2:0]        search start index
//   gnt_valid_o       any request present
//   gnt_onehot_o[7:0] one-hot grant (zero when no request)
//   gnt_idx_o[2:0]    binary grant index

module pmod_da4_rr_arbiter (
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  output logic       gnt_valid_o,
  output logic [7:0] gnt_onehot_o,
  output logic [2:0] gnt_idx_o
);

  logic [2:0] cand;

  // Scan from the farthest offset down so the nearest request to ptr_i wins last.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = 3'd0;
    cand        = 3'd0;
    for (int off = 7; off >= 0; off--) begin
      cand = ptr_i + 3'(off);
      if (req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
    gnt_onehot_o = gnt_valid_o ? (8'b1 << gnt_idx_o) : 8'b0;
  end

endmodule

// File: rtl/pmod_da4_spi_sequencer.sv
// rtl/pmod_da4_spi_sequencer.sv - AD5628 frame sequencer: reference setup then round-robin channel updates
//
// Purpose: after reset sends the internal-reference frame, then serves
// channels with pending writes in round-robin order, one 32-bit SPI frame each.
//   ACLK     system clock
//   ARESETN  asynchronous active-low reset (assert async, release synchronised here)
//   bus      pmod_da4_spi_sequencer_if.slave (register bank in, DAC pins/status out)

module pmod_da4_spi_sequencer
  import pmod_da4_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4,
  parameter int NUM_CH     = 8,
  parameter int REF_ON     = 1
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  pmod_da4_spi_sequencer_if.slave   bus
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  // Release of ARESETN is retimed to ACLK; assertion still propagates immediately.
  logic rst_meta_q, rst_n_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  state_e            state_q;
  logic              sync_n_q, sclk_q, din_q, busy_q, init_done_q;
  logic [NUM_CH-1:0] ch_done_q, pending_q, pending_d, load_clr;
  logic [NUM_CH-1:0] sel_oh_q;
  logic [2:0]        rr_ptr_q, sel_q;
  logic [31:0]       shreg_q;
  logic [4:0]        bit_q;
  logic [15:0]       div_q;
  logic              phase_low_q;
  logic              is_ref_q;
  logic              soft_pend_q;
  logic [11:0]       sel_data;

  logic              gnt_valid;
  logic [NUM_CH-1:0] gnt_onehot;
  logic [2:0]        gnt_idx;

  pmod_da4_rr_arbiter u_arb (
    .req_i        (pending_q),
    .ptr_i        (rr_ptr_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx)
  );

  always_comb begin
    sel_data = 12'h000;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == 3'(i)) sel_data = bus.ch_data[12*i +: 12];
    end
  end

  // A strobe landing in the LOAD cycle re-arms the flag so the newer value goes out next.
  assign load_clr  = (state_q == ST_LOAD) ? sel_oh_q : '0;
  assign pending_d = (pending_q & ~load_clr) | bus.ch_wr;

  always_ff @(posedge ACLK or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q     <= ST_RESET_WAIT;
      sync_n_q    <= 1'b1;
      sclk_q      <= 1'b1;
      din_q       <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      ch_done_q   <= '0;
      pending_q   <= '0;
      sel_oh_q    <= '0;
      rr_ptr_q    <= 3'd0;
      sel_q       <= 3'd0;
      shreg_q     <= 32'h0;
      bit_q       <= 5'd0;
      div_q       <= 16'd0;
      phase_low_q <= 1'b0;
      is_ref_q    <= 1'b0;
      soft_pend_q <= 1'b0;
    end else begin
      ch_done_q <= '0;
      pending_q <= pending_d;
      if (bus.soft_init) soft_pend_q <= 1'b1;

      case (state_q)
        ST_RESET_WAIT: begin
          if (REF_ON != 0) begin
            state_q <= ST_INIT;
          end else begin
            state_q     <= ST_IDLE;
            init_done_q <= 1'b1;
          end
        end

        ST_INIT: begin
          shreg_q     <= REF_ON_WORD;
          din_q       <= REF_ON_WORD[31];
          sync_n_q    <= 1'b0;
          sclk_q      <= 1'b1;
          busy_q      <= 1'b1;
          is_ref_q    <= 1'b1;
          bit_q       <= 5'd31;
          div_q       <= 16'd0;
          phase_low_q <= 1'b0;
          state_q     <= ST_SHIFT;
        end

        ST_IDLE: begin
          if (bus.soft_init || soft_pend_q) begin
            soft_pend_q <= 1'b0;
            state_q     <= ST_INIT;
          end else if (gnt_valid) begin
            sel_q    <= gnt_idx;
            sel_oh_q <= gnt_onehot;
            state_q  <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          shreg_q     <= build_frame(CMD_WRITE_UPDATE, {1'b0, sel_q}, sel_data);
          din_q       <= 1'b0;  // bit 31 of every channel frame is zero
          sync_n_q    <= 1'b0;
          sclk_q      <= 1'b1;
          busy_q      <= 1'b1;
          is_ref_q    <= 1'b0;
          bit_q       <= 5'd31;
          div_q       <= 16'd0;
          phase_low_q <= 1'b0;
          rr_ptr_q    <= sel_q + 3'd1;
          state_q     <= ST_SHIFT;
        end

        // Each bit: CLK_DIV cycles high with DIN valid, then CLK_DIV low.
        // DIN only changes together with SCLK rising, so it is stable over the falling edge.
        ST_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= 16'd0;
            if (!phase_low_q) begin
              sclk_q      <= 1'b0;
              phase_low_q <= 1'b1;
            end else if (bit_q == 5'd0) begin
              sclk_q  <= 1'b1;
              state_q <= ST_TAIL;
            end else begin
              bit_q       <= bit_q - 5'd1;
              shreg_q     <= {shreg_q[30:0], 1'b0};
              din_q       <= shreg_q[30];
              sclk_q      <= 1'b1;
              phase_low_q <= 1'b0;
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end

        ST_TAIL: begin
          if (div_q == DIV_LAST) begin
            div_q    <= 16'd0;
            sync_n_q <= 1'b1;
            din_q    <= 1'b0;
            state_q  <= ST_GAP;
            if (is_ref_q) init_done_q <= 1'b1;
            else          ch_done_q   <= sel_oh_q;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end

        ST_GAP: begin
          if (div_q == GAP_LAST) begin
            div_q   <= 16'd0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end

        default: state_q <= ST_RESET_WAIT;
      endcase
    end
  end

  assign bus.SYNC_N    = sync_n_q;
  assign bus.SCLK      = sclk_q;
  assign bus.DIN       = din_q;
  assign bus.busy      = busy_q;
  assign bus.init_done = init_done_q;
  assign bus.ch_done   = ch_done_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_pmod_da4_spi_sequencer.sv
// tb/tb_pmod_da4_spi_sequencer.sv - scoreboard bench for the PMOD DA4 SPI sequencer

module tb_pmod_da4_spi_sequencer;

  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 4;
  localparam int SYNC_LOW   = 64 * CLK_DIV + CLK_DIV;
  localparam int PERIOD     = 2 + 64 * CLK_DIV + CLK_DIV + GAP_CYCLES;
  localparam logic [31:0] REF_WORD = 32'h08000001;

  logic ACLK = 1'b0;
  logic ARESETN;

  pmod_da4_spi_sequencer_if #(.NUM_CH(8)) bus ();

  pmod_da4_spi_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .NUM_CH     (8),
    .REF_ON     (1)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   falls[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_pulses = 0;
  int   exp_done    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] upd_word(input int n, input logic [11:0] d);
    logic [3:0] a;
    a = 4'(n);
    return {8'h03, a, d, 8'h00};
  endfunction

  task automatic push_upd(input int n, input logic [11:0] d);
    exp_t e;
    e.word = upd_word(n, d);
    e.mask = 8'(1 << n);
    exp_q.push_back(e);
    exp_done++;
  endtask

  task automatic push_ref();
    exp_t e;
    e.word = REF_WORD;
    e.mask = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic set_ch(input int n, input logic [11:0] v);
    bus.ch_data[12*n +: 12] = v;
  endtask

  task automatic pulse_wr(input logic [7:0] m);
    bus.ch_wr = m;
    @(posedge ACLK); #1;
    bus.ch_wr = 8'h00;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge ACLK);
      n++;
    end while ((exp_q.size() != 0 || bus.busy || bus.pending != 0) && n < budget);
    #1;
    check({tag, "_timeout"}, 32'(n >= budget), 32'd0);
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // Frame decoder: samples on the falling ACLK edge, shifts DIN in on each SCLK fall.
  logic        in_frame = 1'b0;
  logic        prev_sync = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0;
  logic [31:0] word;
  int          nbits, low_cnt;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      in_frame  = 1'b0;
      prev_sync = 1'b1;
      prev_sclk = 1'b1;
      prev_din  = 1'b0;
    end else begin
      done_pulses += $countones(bus.ch_done);
      if (prev_sync && !bus.SYNC_N) begin
        in_frame = 1'b1;
        word     = 32'h0;
        nbits    = 0;
        low_cnt  = 0;
        falls.push_back(cyc);
      end
      if (in_frame && !bus.SYNC_N) begin
        low_cnt++;
        if (prev_sclk && !bus.SCLK) begin
          check("din_stable_at_fall", 32'(bus.DIN), 32'(prev_din));
          word = {word[30:0], bus.DIN};
          nbits++;
        end
      end
      if (in_frame && bus.SYNC_N) begin
        in_frame = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_frame_queue_size", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("frame_word", word, e.word);
          check("frame_bits", 32'(nbits), 32'd32);
          check("sync_low_cycles", 32'(low_cnt), 32'(SYNC_LOW));
          check("ch_done_at_end", 32'(bus.ch_done), 32'(e.mask));
          if (e.mask == 8'h00) check("init_done_at_ref_end", 32'(bus.init_done), 32'd1);
        end
      end
      prev_sync = bus.SYNC_N;
      prev_sclk = bus.SCLK;
      prev_din  = bus.DIN;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    ARESETN       = 1'b0;
    bus.ch_data   = '0;
    bus.ch_wr     = '0;
    bus.soft_init = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_sync_n",    32'(bus.SYNC_N),    32'd1);
    check("rst_sclk",      32'(bus.SCLK),      32'd1);
    check("rst_din",       32'(bus.DIN),       32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    check("rst_ch_done",   32'(bus.ch_done),   32'd0);
    check("rst_pending",   32'(bus.pending),   32'd0);

    // Reference frame after reset release.
    push_ref();
    ARESETN = 1'b1;
    wait_drain(2000, "init");
    check("init_done_after_ref", 32'(bus.init_done), 32'd1);
    check("ch_done_after_ref",   32'(done_pulses),   32'd0);

    // All eight channels at once with rr_ptr at 0: addresses 0..7, back to back.
    for (int n = 0; n < 8; n++) begin
      set_ch(n, 12'(n * 12'h111 + 12'h0A5));
      push_upd(n, 12'(n * 12'h111 + 12'h0A5));
    end
    falls.delete();
    pulse_wr(8'hFF);
    wait_drain(3000, "burst");
    check("burst_frame_count", 32'(falls.size()), 32'd8);
    for (int i = 1; i < falls.size(); i++)
      check("burst_frame_period", 32'(falls[i] - falls[i-1]), 32'(PERIOD));

    // Single channel 2 update.
    set_ch(2, 12'hABC);
    push_upd(2, 12'hABC);
    pulse_wr(8'h04);
    check("ch2_pending_set", 32'(bus.pending[2]), 32'd1);
    wait_drain(1000, "ch2");
    check("ch2_pending_clear", 32'(bus.pending[2]), 32'd0);

    // Re-write channel 5 in its own LOAD cycle: old value then new value.
    set_ch(5, 12'h123);
    push_upd(5, 12'h123);
    push_upd(5, 12'h456);
    bus.ch_wr = 8'h20;
    @(posedge ACLK); #1;
    bus.ch_wr = 8'h00;
    @(posedge ACLK); #1;
    bus.ch_wr = 8'h20;
    @(posedge ACLK); #1;
    bus.ch_wr = 8'h00;
    set_ch(5, 12'h456);
    check("ch5_load_sync_low", 32'(bus.SYNC_N), 32'd0);
    check("ch5_pending_kept", 32'(bus.pending[5]), 32'd1);
    wait_drain(1000, "ch5");

    // soft_init mid-frame with channel 1 pending: current frame, reference, then channel 1.
    set_ch(4, 12'h7E1);
    push_upd(4, 12'h7E1);
    pulse_wr(8'h10);
    repeat (30) @(posedge ACLK);
    #1;
    check("soft_init_mid_frame_busy", 32'(bus.busy), 32'd1);
    set_ch(1, 12'h2C3);
    push_ref();
    push_upd(1, 12'h2C3);
    bus.soft_init = 1'b1;
    bus.ch_wr     = 8'h02;
    @(posedge ACLK); #1;
    bus.soft_init = 1'b0;
    bus.ch_wr     = 8'h00;
    check("ch1_pending_during_frame", 32'(bus.pending[1]), 32'd1);
    wait_drain(2000, "soft_init");

    // Reset at bit 15 of a channel 6 frame.
    set_ch(6, 12'h5A5);
    pulse_wr(8'h40);
    begin
      int n;
      n = 0;
      while (bus.SYNC_N && n < 20) begin
        @(posedge ACLK); #1;
        n++;
      end
      check("ch6_frame_started", 32'(bus.SYNC_N), 32'd0);
    end
    repeat (16 * 2 * CLK_DIV) @(posedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    check("abort_sync_n",    32'(bus.SYNC_N),    32'd1);
    check("abort_sclk",      32'(bus.SCLK),      32'd1);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_pending",   32'(bus.pending),   32'd0);
    check("abort_init_done", 32'(bus.init_done), 32'd0);
    exp_q.delete();
    push_ref();
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    wait_drain(2000, "reinit");
    check("reinit_done", 32'(bus.init_done), 32'd1);
    repeat (50) @(posedge ACLK);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ch_done_pulse_total", 32'(done_pulses), 32'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
